// File: rtl/blockmem_1p_arb.sv
`default_nettype none
// ============================================================================
// Module   : blockmem_1p_arb
// Brief    : Round-robin arbiter with per-requester lock sharing one port of a
//            single-port block memory; routes read responses back to issuer.
//            Option macro: BLOCKMEM_ARB_RDATA_REG_EN (registered read outputs).
// Revision : 1.0 - initial release
// ============================================================================
module blockmem_1p_arb #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_BWENABLE  = 0,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int G_PADWIDTH  = (G_DATAWIDTH + 7) & ~7,
  parameter int G_WEWIDTH   = (((G_PADWIDTH - 1) / 8) * G_BWENABLE) + 1,
  parameter int G_RDLAT     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   p0_req,
  input  logic                   p0_lock,
  input  logic [G_WEWIDTH-1:0]   p0_we,
  input  logic [G_ADDRWIDTH-1:0] p0_addr,
  input  logic [G_DATAWIDTH-1:0] p0_wdata,
  output logic                   p0_gnt,
  output logic                   p0_rvalid,
  output logic [G_DATAWIDTH-1:0] p0_rdata,
  input  logic                   p1_req,
  input  logic                   p1_lock,
  input  logic [G_WEWIDTH-1:0]   p1_we,
  input  logic [G_ADDRWIDTH-1:0] p1_addr,
  input  logic [G_DATAWIDTH-1:0] p1_wdata,
  output logic                   p1_gnt,
  output logic                   p1_rvalid,
  output logic [G_DATAWIDTH-1:0] p1_rdata,
  output logic                   mem_en,
  output logic [G_WEWIDTH-1:0]   mem_we,
  output logic [G_ADDRWIDTH-1:0] mem_addr,
  output logic [G_DATAWIDTH-1:0] mem_din,
  input  logic [G_DATAWIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_gnt;
  logic                 w_arb_mode;
  logic                 w_gnt0;
  logic                 w_gnt1;
  logic [G_WEWIDTH-1:0] w_we;
  logic                 w_push_vld;
  logic                 w_out_vld;
  logic                 w_out_own;
  logic [G_RDLAT-1:0]   r_pipe_vld;
  logic [G_RDLAT-1:0]   r_pipe_own;

  // A lock holder that is neither requesting nor holding lock hands the
  // cycle back to normal arbitration, so releasing costs no idle cycle.
  always_comb begin
    w_arb_mode  = 1'b0;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = ST_ARB;
    case (r_state)
      ST_LOCK0: w_arb_mode = !p0_req && !p0_lock;
      ST_LOCK1: w_arb_mode = !p1_req && !p1_lock;
      default:  w_arb_mode = 1'b1;
    endcase
    if (!rst) begin
      if (w_arb_mode) begin
        w_gnt0 = p0_req && (!p1_req || r_last_gnt);
        w_gnt1 = p1_req && (!p0_req || !r_last_gnt);
      end else if (r_state == ST_LOCK0) begin
        w_gnt0 = p0_req;
      end else begin
        w_gnt1 = p1_req;
      end
    end
    if (w_gnt0 && p0_lock) begin
      w_state_nxt = ST_LOCK0;
    end else if (w_gnt1 && p1_lock) begin
      w_state_nxt = ST_LOCK1;
    end else if (r_state == ST_LOCK0 && !w_arb_mode && !w_gnt0) begin
      w_state_nxt = ST_LOCK0;
    end else if (r_state == ST_LOCK1 && !w_arb_mode && !w_gnt1) begin
      w_state_nxt = ST_LOCK1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ARB;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt0 || w_gnt1) begin
        r_last_gnt <= w_gnt1;
      end
    end
  end

  assign p0_gnt     = w_gnt0;
  assign p1_gnt     = w_gnt1;
  assign w_we       = w_gnt1 ? p1_we : p0_we;
  assign mem_en     = w_gnt0 || w_gnt1;
  assign mem_we     = mem_en ? w_we : '0;
  assign mem_addr   = w_gnt1 ? p1_addr : p0_addr;
  assign mem_din    = w_gnt1 ? p1_wdata : p0_wdata;
  assign w_push_vld = mem_en && (w_we == '0);

  // Read-tracking pipe: entry k holds {valid, owner} of the access k+1 cycles old.
  generate
    if (G_RDLAT == 1) begin : g_pipe_one
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pipe_vld <= '0;
          r_pipe_own <= '0;
        end else begin
          r_pipe_vld <= w_push_vld;
          r_pipe_own <= w_gnt1;
        end
      end
    end else begin : g_pipe_multi
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pipe_vld <= '0;
          r_pipe_own <= '0;
        end else begin
          r_pipe_vld <= {r_pipe_vld[G_RDLAT-2:0], w_push_vld};
          r_pipe_own <= {r_pipe_own[G_RDLAT-2:0], w_gnt1};
        end
      end
    end
  endgenerate

  assign w_out_vld = r_pipe_vld[G_RDLAT-1];
  assign w_out_own = r_pipe_own[G_RDLAT-1];

`ifdef BLOCKMEM_ARB_RDATA_REG_EN
  logic                   r_p0_rvalid;
  logic                   r_p1_rvalid;
  logic [G_DATAWIDTH-1:0] r_p0_rdata;
  logic [G_DATAWIDTH-1:0] r_p1_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_p0_rvalid <= w_out_vld && !w_out_own;
      r_p1_rvalid <= w_out_vld && w_out_own;
      r_p0_rdata  <= (w_out_vld && !w_out_own) ? mem_dout : '0;
      r_p1_rdata  <= (w_out_vld && w_out_own) ? mem_dout : '0;
    end
  end

  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
`else
  assign p0_rvalid = w_out_vld && !w_out_own;
  assign p1_rvalid = w_out_vld && w_out_own;
  assign p0_rdata  = mem_dout;
  assign p1_rdata  = mem_dout;
`endif

endmodule
`default_nettype wire
